// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_queue                                            |
// | Description : Instruction prefetcher. Issues one word-aligned read at a     |
// |               time to instruction memory and buffers the returned words    |
// |               with their addresses in a small FIFO for the decode stage.  |
// |               A redirect flushes the FIFO, restarts fetch at the new PC    |
// |               and drops the data of any read that is still in flight.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                       |
// |   clk_i          in   1   clock, rising edge                               |
// |   rst_i          in   1   asynchronous reset, active low                   |
// |   redirect_i     in   1   taken branch / jump                              |
// |   redirect_pc_i  in  32   new fetch address (low two bits ignored)         |
// |   mem_req_o      out  1   memory read request                              |
// |   mem_addr_o     out 32   memory read address, word aligned                |
// |   mem_ack_i      in   1   read complete, mem_rdata_i valid this cycle      |
// |   mem_rdata_i    in  32   instruction word                                 |
// |   instr_valid_o  out  1   queue head available                             |
// |   instr_o        out 32   head instruction                                 |
// |   instr_pc_o     out 32   head instruction address                         |
// |   instr_ready_i  in   1   consumer takes the head this cycle               |
// +----------------------------------------------------------------------------+
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned    PW          = $clog2(DEPTH);
  localparam int unsigned    CW          = PW + 1;
  localparam logic [CW-1:0]  C_DEPTH     = CW'(DEPTH);
  localparam logic [31:0]    C_RESET_PC  = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          do_pop;
  logic          do_push;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] count_after_push;
  logic [31:0]   redirect_pc;
  logic [31:0]   next_pc;
  logic [31:0]   addr_plus4;
  logic          unused_redirect_lsb;

  // Only whole words are fetched; the byte offset of a redirect is dropped.
  assign redirect_pc         = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign addr_plus4          = addr_q + 32'd4;

  // A redirect wins over both queue operations: the head popped in that
  // cycle and the word returned in that cycle belong to the old stream.
  assign do_pop  = (count_q != '0) && instr_ready_i && !redirect_i;
  assign do_push = (state_q == ST_REQ) && mem_ack_i && !redirect_i;

  assign count_after_pop  = count_q - CW'(do_pop);
  assign count_after_push = count_after_pop + CW'(do_push);

  // Address for a fresh request issued this edge: the redirect target wins
  // over the sequential fetch PC.
  assign next_pc = redirect_i ? redirect_pc : fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc;
    end

    case (state_q)
      ST_IDLE: begin
        // Issue only when the word it returns is guaranteed a free slot.
        if (redirect_i || (count_after_pop < C_DEPTH)) begin
          state_d = ST_REQ;
          addr_d  = next_pc;
        end
      end

      ST_REQ: begin
        if (mem_ack_i) begin
          if (redirect_i) begin
            state_d = ST_REQ;
            addr_d  = redirect_pc;
          end else begin
            fetch_pc_d = addr_plus4;
            addr_d     = addr_plus4;
            state_d    = (count_after_push < C_DEPTH) ? ST_REQ : ST_IDLE;
          end
        end else if (redirect_i) begin
          // Read already on the bus: keep its address until it completes.
          state_d = ST_DISCARD;
        end
      end

      ST_DISCARD: begin
        if (mem_ack_i) begin
          // Queue was flushed on entry, so there is always room.
          state_d = ST_REQ;
          addr_d  = next_pc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    count_d  = count_after_push;
    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= C_RESET_PC;
      addr_q     <= C_RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while empty
  // after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (do_push) begin
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= addr_q;
    end
  end

  assign mem_req_o     = (state_q != ST_IDLE);
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are 2, 4 and 8.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 redirect_i  input  1  SHALL indicate a taken branch or jump; sampled on the rising edge.
REQ-006 redirect_pc_i  input  32  SHALL carry the new fetch address, valid when redirect_i=1.
REQ-007 mem_req_o  output  1  SHALL request an instruction-memory read.
REQ-008 mem_addr_o  output  32  SHALL carry the read address, word aligned.
REQ-009 mem_ack_i  input  1  SHALL complete the request; mem_rdata_i is valid in the same cycle.
REQ-010 mem_rdata_i  input  32  SHALL carry the instruction word.
REQ-011 instr_valid_o  output  1  SHALL indicate that instr_o and instr_pc_o hold the queue head.
REQ-012 instr_o  output  32  SHALL carry the head instruction.
REQ-013 instr_pc_o  output  32  SHALL carry the head instruction's address.
REQ-014 instr_ready_i  input  1  SHALL indicate that the consumer takes the head this cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE (no request), REQ (request outstanding), DISCARD (outstanding request whose data will be dropped).
REQ-016 mem_req_o SHALL be 1 exactly in REQ or DISCARD. mem_addr_o SHALL equal the address of the outstanding request and SHALL be stable until the cycle of mem_ack_i=1.
REQ-017 At most one memory request SHALL be outstanding.
REQ-018 IDLE->REQ SHALL occur when the occupancy after this edge's pop is less than DEPTH; the request address SHALL be fetch_pc.
REQ-019 In REQ with mem_ack_i=1 and no redirect, the following SHALL occur on that edge:
- {mem_rdata_i, mem_addr_o} is pushed into the queue.
- fetch_pc becomes mem_addr_o+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- The FSM stays in REQ if post-push occupancy is below DEPTH, otherwise it goes to IDLE.
REQ-020 Push and pop SHALL be allowed in the same cycle; occupancy then does not change. An ack SHALL never find the queue full, because of the issue rule in REQ-018.
REQ-021 A pop SHALL occur when instr_valid_o=1 and instr_ready_i=1. instr_valid_o SHALL equal occupancy != 0.
REQ-022 While instr_valid_o=1 and instr_ready_i=0, instr_o and instr_pc_o SHALL hold their values.
REQ-023 Latency SHALL be:
- An ack in cycle N into an empty queue gives instr_valid_o=1 in cycle N+1.
- With zero-wait memory and a ready consumer, sustained throughput is one instruction per cycle.
REQ-024 redirect_i=1 SHALL, on that edge:
- flush every queue entry;
- discard any pop that cycle;
- set fetch_pc to {redirect_pc_i[31:2], 2'b00}.
REQ-025 The FSM transition on redirect SHALL depend on the request state that cycle:
- Redirect in REQ or DISCARD without ack: go to DISCARD; the old address stays on mem_addr_o until ack.
- Redirect in the same cycle as an ack: the acked data is dropped, and the FSM goes to REQ at the new fetch_pc.
- Redirect in IDLE: go to REQ at the new fetch_pc.
REQ-026 In DISCARD, mem_ack_i=1 without redirect SHALL drop the data and move the FSM to REQ at fetch_pc.
REQ-027 Two consecutive redirects SHALL leave the last redirect_pc_i as fetch_pc. Instructions from an earlier stream SHALL never appear on instr_o after a later redirect.
REQ-028 Occupancy SHALL use a count of width clog2(DEPTH)+1, with read and write pointers that wrap modulo DEPTH.

Reset
REQ-029 While rst_i=0 the block SHALL hold the following values:
- state=IDLE, mem_req_o=0, mem_addr_o=RESET_PC;
- occupancy=0, instr_valid_o=0, instr_o=0, instr_pc_o=0;
- fetch_pc=RESET_PC.
REQ-030 Asserting reset mid-request SHALL abandon the request immediately, with no wait for ack. mem_req_o SHALL first become 1 in the cycle after the first rising edge following release.

Verification
REQ-031 Basic fetch: reset release, memory acks in the same cycle, instr_ready_i=1 -> instr_pc_o runs 0x0, 0x4, 0x8, ... one per cycle, instr_valid_o first high 2 cycles after release.
REQ-032 Fill: DEPTH=4, instr_ready_i=0 -> exactly 4 acks, then mem_req_o=0 and instr_o holds the 0x0 word; one pop -> mem_req_o=1 again at address 0x10.
REQ-033 Redirect during a wait: request to 0x8 is outstanding and unacked for 3 cycles, redirect_pc_i=0x100 -> mem_addr_o stays 0x8 until ack, that data is dropped, the next request is to 0x100, and the first instr_pc_o after the redirect is 0x100.
REQ-034 Redirect with ack and pop in the same cycle: redirect_pc_i=0x203 -> queue empty next cycle, next request to 0x200, no stale instruction delivered.
REQ-035 Wrap: RESET_PC=32'hFFFF_FFF8 -> instr_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Reset mid-operation: rst_i=0 with 3 entries queued and a request outstanding -> all outputs reach their REQ-029 values without a clock edge.
